fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter LOOP, default 1: 1 wraps PC 15->0 and continues; 0 halts after issuing address 15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 run  input  1  level; continuous fetch/issue enable.
REQ-005 step  input  1  one-cycle pulse; fetch and issue exactly one instruction.
REQ-006 restart  input  1  one-cycle pulse; PC to 0, return to IDLE.
REQ-007 rom_addr  output  4  address to the 16x16 program ROM.
REQ-008 rom_data  input  16  combinational ROM word for rom_addr.
REQ-009 issue_valid  output  1  decoded instruction presented to datapath.
REQ-010 issue_ready  input  1  datapath accepts the presented instruction.
REQ-011 issue_op  output  4  instr[15:12]: 0000 nop, 0001 addi, 1111 out.
REQ-012 issue_rd  output  3  instr[11:9], register index.
REQ-013 issue_imm  output  8  instr[7:0], immediate.
REQ-014 issue_pc  output  4  address the presented instruction was fetched from.
REQ-015 halted  output  1  high while in HALT.
REQ-016 wrap  output  1  one-cycle pulse on PC transition 15->0.

Function
REQ-017 States: IDLE, FETCH, ISSUE, HALT; 4-bit PC register; 16-bit instruction register (IR).
REQ-018 rom_addr SHALL equal PC at all times.
REQ-019 IDLE: run=1 or step=1 -> FETCH; step latched into a single-step flag; else stay.
REQ-020 FETCH: IR <= rom_data, issue_pc <= PC, -> ISSUE (one cycle, unconditional).
REQ-021 ISSUE: issue_valid=1; issue_op/rd/imm/pc driven from IR and SHALL NOT change until handshake.
REQ-022 Handshake = issue_valid & issue_ready at a rising edge; exactly one transfer per ISSUE visit.
REQ-023 On handshake: PC <= PC+1 modulo 16; if PC was 15 and LOOP=0 -> HALT (PC stays 15); else if single-step flag set or run=0 -> IDLE (flag cleared); else -> FETCH.
REQ-024 wrap pulses in the cycle after a handshake at PC=15 with LOOP=1; never when LOOP=0.
REQ-025 Latency: run rising in IDLE -> issue_valid high 2 cycles later; steady-state throughput one instruction per 2 cycles with issue_ready held high.
REQ-026 run falling during FETCH or ISSUE: current instruction completes its handshake, then IDLE; no instruction dropped or duplicated.
REQ-027 step outside IDLE: ignored; step and run both high in IDLE: single-step flag set, one instruction only.
REQ-028 All opcodes, including nop and unlisted codes, issued unmodified; no decode-based skipping.
REQ-029 HALT: issue_valid=0, halted=1; run/step ignored; only restart or reset exits.
REQ-030 restart: highest priority in every state; next cycle PC=0, state IDLE, issue_valid=0, flag cleared, wrap=0; a pending unaccepted instruction is discarded.
REQ-031 issue_ready while issue_valid=0 SHALL have no effect.

Reset
REQ-032 rst_n low: immediately state=IDLE, PC=0, IR=0, issue_valid=0, issue_op/rd/imm/pc=0, halted=0, wrap=0, flag cleared.
REQ-033 rst_n assertion mid-ISSUE aborts without handshake; after release first fetch is address 0.

Verification
REQ-034 Reset, run=1, issue_ready=1, ROM word0=0x1202 -> issue_valid at cycle 2 with op=1, rd=1, imm=0x02, pc=0; next issue op=0, rd=1, pc=1.
REQ-035 step pulse in IDLE, word2=0xF200, PC=2 -> one issue op=0xF, rd=1, imm=0, pc=2; then IDLE, PC=3, no further issue_valid for 10 cycles.
REQ-036 issue_ready low for 5 cycles during ISSUE -> outputs stable all 5 cycles; single handshake; PC advances by exactly 1.
REQ-037 LOOP=1, run=1 through 16 handshakes -> wrap pulses once after pc=15 issue (word15=0x0200), next issue pc=0; LOOP=0 -> halted=1 after pc=15, issue_valid stays 0 until restart.
REQ-038 restart pulse while in ISSUE at PC=9 and issue_ready=0 -> next cycle IDLE, PC=0, issue_valid=0, no handshake counted.
REQ-039 rst_n low for 1 cycle mid-ISSUE at PC=6 -> all outputs zero asynchronously; run=1 after release refetches address 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue sequencer for a 16-word program ROM.
// Fetches one word per visit to FETCH and holds it in ISSUE until the datapath accepts it.
module fetch_sequencer #(
    parameter bit LOOP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        step,
    input  logic        restart,
    output logic [3:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [3:0]  issue_op,
    output logic [2:0]  issue_rd,
    output logic [7:0]  issue_imm,
    output logic [3:0]  issue_pc,
    output logic        halted,
    output logic        wrap
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALT
    } state_t;

    state_t      state;
    logic [3:0]  pc;
    logic [15:0] ir;
    logic        single_step;
    logic        handshake;
    logic        unused_ir_bit;

    assign rom_addr      = pc;
    assign handshake     = issue_valid & issue_ready;
    assign issue_op      = ir[15:12];
    assign issue_rd      = ir[11:9];
    assign issue_imm     = ir[7:0];
    assign unused_ir_bit = ir[8];

    // restart overrides every state; wrap is a single-cycle pulse so it defaults low each edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= 4'd0;
            ir          <= 16'd0;
            issue_pc    <= 4'd0;
            issue_valid <= 1'b0;
            single_step <= 1'b0;
            halted      <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (restart) begin
                state       <= IDLE;
                pc          <= 4'd0;
                issue_valid <= 1'b0;
                single_step <= 1'b0;
                halted      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (run || step) begin
                            state       <= FETCH;
                            single_step <= step;
                        end
                    end
                    FETCH: begin
                        ir          <= rom_data;
                        issue_pc    <= pc;
                        issue_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                    ISSUE: begin
                        if (handshake) begin
                            issue_valid <= 1'b0;
                            if (pc == 4'd15 && !LOOP) begin
                                state  <= HALT;
                                halted <= 1'b1;
                            end else begin
                                pc   <= pc + 4'd1;
                                wrap <= (pc == 4'd15) && LOOP;
                                if (single_step || !run) begin
                                    state       <= IDLE;
                                    single_step <= 1'b0;
                                end else begin
                                    state <= FETCH;
                                end
                            end
                        end
                    end
                    HALT: begin
                        halted      <= 1'b1;
                        issue_valid <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
